tour_cmd_gen: RTL and testbench

- Parametrised successor to the tour command translator.
- Once the tour solver finishes, it takes over the command path from the UART (usurp) and walks the move list.
- Each one-hot knight move becomes two cmd_proc commands: a 2-square leg on one axis and a 1-square leg on the other.
- Generalised over tour length, leg order, fanfare enable and opcode/response encodings; adds abort and illegal-move detection.

---
 rtl/tour_cmd_gen.sv | 83 ++++++++
 tb/tb_tour_cmd_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd_gen.sv
// tour_cmd_gen: walks the solved knight's tour and issues two cmd_proc legs per move
module tour_cmd_gen #(
  parameter int         NUM_MOVES  = 24,
  parameter int         IDX_W      = 5,
  parameter bit         FIRST_AXIS = 1'b0,
  parameter bit         FANFARE_EN = 1'b1,
  parameter logic [3:0] MOVE_OP    = 4'h2,
  parameter logic [3:0] FANFARE_OP = 4'h3,
  parameter logic [7:0] RESP_INT   = 8'h5A,
  parameter logic [7:0] RESP_DONE  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic [7:0]       move,
  input  logic             abort,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [IDX_W-1:0] mv_indx,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  output logic             usurp,
  output logic [7:0]       resp,
  output logic             tour_done,
  output logic             tour_err
);
  typedef enum logic [2:0] {IDLE, LEG1, WAIT1, LEG2, WAIT2, NEXT} state_t;
  state_t state, nxt;
  logic legal, last, gen_rdy;
  logic dy_pos, dy_big, dx_pos, dx_big;
  logic [11:0] v_leg, h_leg;
  logic [15:0] gen_cmd;
  assign legal  = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);
  assign last   = mv_indx == IDX_W'(NUM_MOVES - 1);
  assign dy_pos = |(move & 8'h87);
  assign dy_big = |(move & 8'h33);
  assign dx_pos = |(move & 8'hE1);
  assign dx_big = |(move & 8'hCC);
  assign v_leg  = {dy_pos ? 8'h00 : 8'h7F, 2'b00, dy_big, ~dy_big};
  assign h_leg  = {dx_pos ? 8'hBF : 8'h3F, 2'b00, dx_big, ~dx_big};
  // state, index, ownership and status pulses; usurp tracks whether the tour stays active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mv_indx   <= '0;
      usurp     <= 1'b0;
      tour_done <= 1'b0;
      tour_err  <= 1'b0;
    end else begin
      state     <= nxt;
      usurp     <= nxt != IDLE;
      mv_indx   <= (state == IDLE && start_tour) ? '0 :
                   (state == NEXT && !abort) ? mv_indx + 1'b1 : mv_indx;
      tour_done <= state == WAIT2 && send_resp && last && !abort;
      tour_err  <= state != IDLE && (abort || (state == LEG1 && !legal));
    end
  end
  // next-state: handshake sequencing, with abort overriding everything outside IDLE
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start_tour ? LEG1 : IDLE;
      LEG1:  nxt = !legal ? IDLE : clr_cmd_rdy ? WAIT1 : LEG1;
      WAIT1: nxt = send_resp ? LEG2 : WAIT1;
      LEG2:  nxt = clr_cmd_rdy ? WAIT2 : LEG2;
      WAIT2: nxt = send_resp ? (last ? IDLE : NEXT) : WAIT2;
      NEXT:  nxt = LEG1;
      default: nxt = IDLE;
    endcase
    if (abort && state != IDLE) nxt = IDLE;
  end
  // outputs: generated leg while the tour owns the path, UART pass-through otherwise
  always_comb begin
    gen_rdy = (state == LEG1 && legal) || state == LEG2;
    gen_cmd = state == LEG2 ? {FANFARE_EN ? FANFARE_OP : MOVE_OP, FIRST_AXIS ? v_leg : h_leg}
                            : {MOVE_OP, FIRST_AXIS ? h_leg : v_leg};
    cmd     = usurp ? gen_cmd : cmd_UART;
    cmd_rdy = usurp ? gen_rdy : cmd_rdy_UART;
    resp    = (!usurp || (state == WAIT2 && last)) ? RESP_DONE : RESP_INT;
  end
endmodule

// File: tb/tb_tour_cmd_gen.sv
// tb_tour_cmd_gen: scoreboarded check of both leg orders over short directed tours
module tb_tour_cmd_gen;
  logic clk = 1'b0, rst_n = 1'b0, start_tour = 1'b0, abort = 1'b0;
  logic cmd_rdy_UART = 1'b0, clr_cmd_rdy = 1'b0, send_resp = 1'b0;
  logic [15:0] cmd_UART = 16'h0000;
  logic [7:0] mem [32];
  logic [4:0] mv_indx_v, mv_indx_h;
  logic [15:0] cmd_v, cmd_h;
  logic cmd_rdy_v, cmd_rdy_h, usurp_v, usurp_h, done_v, done_h, err_v, err_h;
  logic [7:0] resp_v, resp_h;
  logic [15:0] qv [$], qh [$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  tour_cmd_gen #(.NUM_MOVES(2), .FIRST_AXIS(1'b0)) dut_v (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(mem[mv_indx_v]), .abort(abort),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .mv_indx(mv_indx_v), .cmd(cmd_v), .cmd_rdy(cmd_rdy_v),
    .usurp(usurp_v), .resp(resp_v), .tour_done(done_v), .tour_err(err_v));
  tour_cmd_gen #(.NUM_MOVES(2), .FIRST_AXIS(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(mem[mv_indx_h]), .abort(abort),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .mv_indx(mv_indx_h), .cmd(cmd_h), .cmd_rdy(cmd_rdy_h),
    .usurp(usurp_h), .resp(resp_h), .tour_done(done_h), .tour_err(err_h));
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // hand-computed legs: index {h_first, second}
  function automatic logic [15:0] exp_leg(input logic [7:0] mv, input bit h_first, input bit second);
    logic [15:0] t [4];
    case (mv)
      8'h01:   t = '{16'h2002, 16'h3BF1, 16'h2BF1, 16'h3002};
      8'h08:   t = '{16'h27F1, 16'h33F2, 16'h23F2, 16'h37F1};
      8'h40:   t = '{16'h27F1, 16'h3BF2, 16'h2BF2, 16'h37F1};
      8'h04:   t = '{16'h2001, 16'h33F2, 16'h23F2, 16'h3001};
      default: t = '{16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD};
    endcase
    return t[{h_first, second}];
  endfunction
  task automatic push_leg(input logic [7:0] mv, input bit second);
    qv.push_back(exp_leg(mv, 1'b0, second));
    qh.push_back(exp_leg(mv, 1'b1, second));
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start();
    step(); start_tour = 1'b1;
    step(); start_tour = 1'b0;
  endtask
  task automatic wait_rdy();
    int n = 0;
    @(negedge clk);
    while (!(cmd_rdy_v && cmd_rdy_h) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_timeout", {15'd0, cmd_rdy_v & cmd_rdy_h}, 16'd1);
  endtask
  task automatic leg_req();
    wait_rdy();
    step(); clr_cmd_rdy = 1'b1;
    step(); clr_cmd_rdy = 1'b0;
  endtask
  task automatic leg(input logic [7:0] exp_resp);
    leg_req();
    step(); send_resp = 1'b1;
    @(negedge clk);
    chk("resp_v", {8'h00, resp_v}, {8'h00, exp_resp});
    chk("resp_h", {8'h00, resp_h}, {8'h00, exp_resp});
    step(); send_resp = 1'b0;
  endtask
  // scoreboard monitor: every accepted command must match the oldest expected leg
  always @(negedge clk) begin
    if (rst_n && usurp_v && cmd_rdy_v && clr_cmd_rdy) begin
      if (qv.size() == 0) chk("cmd_v_unexpected", cmd_v, 16'hFFFF);
      else chk("cmd_v", cmd_v, qv.pop_front());
    end
    if (rst_n && usurp_h && cmd_rdy_h && clr_cmd_rdy) begin
      if (qh.size() == 0) chk("cmd_h_unexpected", cmd_h, 16'hFFFF);
      else chk("cmd_h", cmd_h, qh.pop_front());
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_usurp", {15'd0, usurp_v}, 16'd0);
    chk("rst_mv_indx", {11'd0, mv_indx_v}, 16'd0);
    chk("rst_done_err", {14'd0, done_v, err_v}, 16'd0);
    chk("rst_cmd_rdy", {15'd0, cmd_rdy_v}, 16'd0);
    chk("rst_resp", {8'h00, resp_v}, 16'h00A5);
    step(); cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
    @(negedge clk);
    chk("pass_cmd", cmd_v, 16'h1234);
    chk("pass_rdy", {15'd0, cmd_rdy_v}, 16'd1);
    step(); cmd_UART = 16'hBEEF;
    mem[0] = 8'h01; mem[1] = 8'h08;
    push_leg(8'h01, 0); push_leg(8'h01, 1); push_leg(8'h08, 0); push_leg(8'h08, 1);
    start();
    @(negedge clk);
    chk("tour_usurp", {14'd0, usurp_v, usurp_h}, 16'd3);
    leg(8'h5A);
    leg(8'h5A);
    @(negedge clk);
    chk("next_mv_indx", {11'd0, mv_indx_v}, 16'd0);
    chk("next_no_rdy", {15'd0, cmd_rdy_v}, 16'd0);
    @(negedge clk);
    chk("next_mv_indx2", {11'd0, mv_indx_v}, 16'd1);
    chk("next_leg_rdy", {15'd0, cmd_rdy_v}, 16'd1);
    leg(8'h5A);
    leg(8'hA5);
    @(negedge clk);
    chk("done_pulse", {14'd0, done_v, done_h}, 16'd3);
    chk("done_usurp", {15'd0, usurp_v}, 16'd0);
    chk("done_pass_cmd", cmd_v, 16'hBEEF);
    chk("done_pass_rdy", {15'd0, cmd_rdy_v}, 16'd1);
    @(negedge clk);
    chk("done_one_cycle", {15'd0, done_v}, 16'd0);
    step(); cmd_rdy_UART = 1'b0;
    mem[0] = 8'h03;
    start();
    @(negedge clk);
    chk("illegal_no_rdy", {14'd0, cmd_rdy_v, cmd_rdy_h}, 16'd0);
    @(negedge clk);
    chk("illegal_err", {14'd0, err_v, err_h}, 16'd3);
    chk("illegal_usurp", {15'd0, usurp_v}, 16'd0);
    @(negedge clk);
    chk("illegal_err_clear", {15'd0, err_v}, 16'd0);
    mem[0] = 8'h01; mem[1] = 8'h08;
    push_leg(8'h01, 0); push_leg(8'h01, 1); push_leg(8'h08, 0);
    start();
    leg(8'h5A);
    leg(8'h5A);
    leg_req();
    step(); send_resp = 1'b1; abort = 1'b1;
    step(); send_resp = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_err", {14'd0, err_v, err_h}, 16'd3);
    chk("abort_usurp", {15'd0, usurp_v}, 16'd0);
    chk("abort_rdy", {15'd0, cmd_rdy_v}, 16'd0);
    chk("abort_mv_indx", {11'd0, mv_indx_v}, 16'd1);
    repeat (3) @(negedge clk);
    chk("abort_no_leg2", {14'd0, cmd_rdy_v, usurp_v}, 16'd0);
    chk("abort_err_clear", {15'd0, err_v}, 16'd0);
    mem[0] = 8'h40; mem[1] = 8'h04;
    push_leg(8'h40, 0); push_leg(8'h40, 1); push_leg(8'h04, 0);
    start();
    leg(8'h5A);
    leg(8'h5A);
    leg(8'h5A);
    @(negedge clk);
    chk("leg2_rdy", {15'd0, cmd_rdy_v}, 16'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_usurp", {14'd0, usurp_v, usurp_h}, 16'd0);
    chk("mid_rst_mv_indx", {11'd0, mv_indx_v}, 16'd0);
    chk("mid_rst_rdy", {15'd0, cmd_rdy_v}, 16'd0);
    chk("mid_rst_pulses", {14'd0, done_v, err_v}, 16'd0);
    step(); step(); rst_n = 1'b1;
    push_leg(8'h40, 0); push_leg(8'h40, 1); push_leg(8'h04, 0); push_leg(8'h04, 1);
    start();
    @(negedge clk);
    chk("restart_mv_indx", {11'd0, mv_indx_v}, 16'd0);
    leg(8'h5A);
    leg(8'h5A);
    leg(8'h5A);
    leg(8'hA5);
    @(negedge clk);
    chk("restart_done", {14'd0, done_v, done_h}, 16'd3);
    chk("qv_drained", 16'(qv.size()), 16'd0);
    chk("qh_drained", 16'(qh.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
